// File: rtl/onehot_dispatch_decoder_if.sv
// rtl/onehot_dispatch_decoder_if.sv - request/target/status bundle for the one-hot dispatch decoder
//
// Purpose: groups the index handshake, the per-target select/ack lines and the
// completion status of onehot_dispatch_decoder.
// Signals:
//   in_valid, in_idx[IDX_LEN]  : request index from the arbitration stage
//   in_ready                   : decoder can accept an index this cycle
//   sel[OUT_LEN]               : registered one-hot select to the targets
//   ack[OUT_LEN]               : per-target acknowledge, level-sampled
//   busy, done, done_idx, err  : transaction status
// Modports: slave = the decoder, master = the requester/target side.
interface onehot_dispatch_decoder_if #(
    parameter int OUT_LEN = 8,
    parameter int IDX_LEN = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [IDX_LEN-1:0] in_idx;
    logic [OUT_LEN-1:0] sel;
    logic [OUT_LEN-1:0] ack;
    logic               busy;
    logic               done;
    logic [IDX_LEN-1:0] done_idx;
    logic               err;

    modport slave (
        input  in_valid, in_idx, ack,
        output in_ready, sel, busy, done, done_idx, err
    );

    modport master (
        output in_valid, in_idx, ack,
        input  in_ready, sel, busy, done, done_idx, err
    );
endinterface

// File: rtl/onehot_dispatch_decoder.sv
// rtl/onehot_dispatch_decoder.sv - binary index to held one-hot select with ack-based completion
//
// Purpose: accepts a binary target index over a valid/ready handshake, drives a
// registered one-hot select to that target until it acknowledges, then pulses
// done. Out-of-range indices pulse err without selecting anything.
// Optional feature: define DISPATCH_TIMEOUT_EN to abort a transaction with err
// after TIMEOUT ACTIVE cycles without the matching ack.
// Ports:
//   clk     : rising-edge clock
//   rst_n   : asynchronous active-low reset
//   enable  : permits acceptance of new requests
//   bus     : onehot_dispatch_decoder_if.slave (handshake, sel/ack, status)
module onehot_dispatch_decoder #(
    parameter int OUT_LEN = 8,
    parameter int IDX_LEN = 3,
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    onehot_dispatch_decoder_if.slave bus
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [IDX_LEN:0] OUT_LIM = (IDX_LEN + 1)'(OUT_LEN);

    state_t             state;
    logic [IDX_LEN-1:0] idx_q;
    logic [OUT_LEN-1:0] sel_q;
    logic               busy_q;
    logic               done_q;
    logic               err_q;
    logic [IDX_LEN-1:0] done_idx_q;

    logic accept;
    logic in_range;
    logic ack_hit;
    logic timeout_hit;

    // rst_n gates in_ready so nothing looks acceptable while reset is held.
    assign bus.in_ready = rst_n && enable && (state == IDLE);
    assign accept       = bus.in_valid && bus.in_ready;
    assign in_range     = {1'b0, bus.in_idx} < OUT_LIM;

    // sel_q is exactly one-hot on the latched index while ACTIVE, so masking
    // ack with it picks out ack[idx_q] and ignores every other bit.
    assign ack_hit = |(bus.ack & sel_q);

`ifdef DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;

    // The count of ack-less ACTIVE cycles already completed; the cycle that
    // would bring it to TIMEOUT is the one that aborts.
    assign timeout_hit = (state == ACTIVE) && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == ACTIVE && !ack_hit && !timeout_hit) begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    logic unused_timeout_cfg;

    assign timeout_hit        = 1'b0;
    assign unused_timeout_cfg = ^TIMEOUT;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx_q      <= '0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            done_idx_q <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_range) begin
                            idx_q  <= bus.in_idx;
                            sel_q  <= OUT_LEN'(1) << bus.in_idx;
                            busy_q <= 1'b1;
                            state  <= ACTIVE;
                        end else begin
                            err_q      <= 1'b1;
                            done_idx_q <= bus.in_idx;
                        end
                    end
                end
                ACTIVE: begin
                    // An ack in the timeout cycle still completes normally.
                    if (ack_hit) begin
                        sel_q      <= '0;
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        done_idx_q <= idx_q;
                        state      <= IDLE;
                    end else if (timeout_hit) begin
                        sel_q      <= '0;
                        busy_q     <= 1'b0;
                        err_q      <= 1'b1;
                        done_idx_q <= idx_q;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel      = sel_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;
    assign bus.done_idx = done_idx_q;

endmodule
